// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC select, imem req/ack and decode handoff.
// Define FETCH_STATS_EN to add the stat_fetch/stat_redirect counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  pc_hi,
  input  logic [31:0] jump_addr,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetch,
  output logic [31:0] stat_redirect
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_pend, w_pend_n;
  logic        r_valid, w_valid_n;
  logic [31:0] r_if_pc, w_if_pc_n;
  logic [31:0] r_instr, w_instr_n;

  logic        w_acc;
  logic [31:0] w_seq;
  logic [31:0] w_br;
  logic [31:0] w_next;
  logic        w_req;
  logic [31:0] w_addr;

  assign w_acc = r_valid & id_ready;
  assign w_seq = r_if_pc + 32'd4;
  assign w_br  = w_seq + {{14{br_offset[15]}}, br_offset, 2'b00};

  always_comb begin
    w_next = w_seq;
    if (jr)            w_next = jr_addr;
    else if (jmp)      w_next = jump_addr;
    else if (br_taken) w_next = w_br;
  end

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_pend_n  = r_pend;
    w_valid_n = r_valid;
    w_if_pc_n = r_if_pc;
    w_instr_n = r_instr;
    w_req     = 1'b0;
    w_addr    = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_state_n = S_FETCH;
        if (flush) w_pc_n = flush_pc;
      end
      S_FETCH: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (imem_ack) begin
          if (flush) begin
            w_pc_n = flush_pc;
          end else begin
            w_instr_n = imem_rdata;
            w_if_pc_n = r_pc;
            w_valid_n = 1'b1;
            w_state_n = S_HOLD;
          end
        end else if (flush) begin
          w_pend_n  = flush_pc;
          w_state_n = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_valid_n = 1'b0;
          w_pc_n    = flush_pc;
          w_state_n = S_FETCH;
        end else if (w_acc) begin
          w_req  = 1'b1;
          w_addr = w_next;
          w_pc_n = w_next;
          if (imem_ack) begin
            w_instr_n = imem_rdata;
            w_if_pc_n = w_next;
          end else begin
            w_valid_n = 1'b0;
            w_state_n = S_FETCH;
          end
        end
      end
      S_DROP: begin
        // stale request must complete before the flush target is fetched
        w_req  = 1'b1;
        w_addr = r_pc;
        if (flush) w_pend_n = flush_pc;
        if (imem_ack) begin
          w_pc_n    = flush ? flush_pc : r_pend;
          w_state_n = S_FETCH;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= 32'h0;
      r_valid <= 1'b0;
      r_if_pc <= 32'h0;
      r_instr <= 32'h0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_pend  <= w_pend_n;
      r_valid <= w_valid_n;
      r_if_pc <= w_if_pc_n;
      r_instr <= w_instr_n;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;
  assign if_valid  = r_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_instr;
  assign pc_hi     = w_seq[31:28];

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetch;
  logic [31:0] r_stat_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetch    <= 32'h0;
      r_stat_redirect <= 32'h0;
    end else if (flush) begin
      r_stat_redirect <= r_stat_redirect + 32'd1;
    end else if (w_acc) begin
      r_stat_fetch <= r_stat_fetch + 32'd1;
      if (jr | jmp | br_taken)
        r_stat_redirect <= r_stat_redirect + 32'd1;
    end
  end

  assign stat_fetch    = r_stat_fetch;
  assign stat_redirect = r_stat_redirect;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage: holds the program counter, selects the next PC and fetches instructions over an imem req/ack handshake.
- Hands each instruction to decode over a valid/ready pair.
- Drives `pc_hi` to the jump-address unit and consumes its 32-bit `jump_addr`, together with branch, `jr` and flush redirects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_hi  out  4  (if_pc+4)[31:28]; feeds jump-address unit
- jump_addr  in  32  jump target returned by jump-address unit
- br_taken  in  1  decoded instruction is a taken branch
- br_offset  in  16  branch immediate, in words
- jmp  in  1  decoded instruction is j/jal
- jr  in  1  decoded instruction is jr/jalr
- jr_addr  in  32  register target for jr
- flush  in  1  pipeline flush, e.g. exception
- flush_pc  in  32  flush target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch complete; may be asserted in the request cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_valid  out  1  if_instr/if_pc valid to decode
- if_pc  out  32  PC of if_instr
- if_instr  out  32  fetched instruction
- id_ready  in  1  decode accepts if_instr this cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; if_valid=0, if_pc=0, if_instr=0, imem_req=0.
  - pc_q=RESET_PC, pend_q=0.
  - Release mid-transfer discards any outstanding request.
- Accept: `acc = if_valid & id_ready`. br_taken/jmp/jr are sampled only on acc; ignored otherwise.
- Next-PC selection when acc, priority jr > jmp > br_taken > sequential:
  - jr: jr_addr
  - jmp: jump_addr
  - br_taken: if_pc + 4 + (sext(br_offset) << 2)
  - sequential: if_pc + 4
- Arithmetic: all additions are mod 2^32, so 32'hFFFF_FFFC + 4 = 0. No delay slot: the redirect takes effect on the very next fetch.
- flush overrides everything, in any state, including acc.
- IDLE:
  - imem_req=0; go to FETCH next cycle.
  - flush in IDLE loads pc_q=flush_pc.
- FETCH:
  - imem_req=1, imem_addr=pc_q; address held stable until ack.
  - ack & !flush: if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, go to HOLD.
  - ack & flush: discard data, pc_q<=flush_pc, stay in FETCH.
  - !ack & flush: pend_q<=flush_pc, go to DROP.
- HOLD (if_valid=1):
  - !acc: outputs held stable, imem_req=0.
  - acc: imem_req=1 combinationally, imem_addr=next_pc, pc_q<=next_pc.
    - ack same cycle: load new instruction, stay in HOLD. Zero-wait memory gives 1 instr/cycle.
    - no ack: if_valid<=0, go to FETCH.
  - flush: if_valid<=0, pc_q<=flush_pc, go to FETCH, imem_req=0 that cycle.
- DROP:
  - imem_req=1, imem_addr=pc_q (the old address).
  - On ack: discard data, pc_q<=pend_q, go to FETCH.
  - Further flush updates pend_q (latest wins).
- if_valid is never asserted with data from a flushed or stale request.
- pc_hi is combinational from if_pc; don't-care while if_valid=0.
- Protocol assertions:
  - imem_addr[1:0]==0 whenever imem_req=1.
  - imem_req is never dropped before imem_ack.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs stat_fetch (32) and stat_redirect (32), reset to 0, wrapping.
  - stat_fetch +1 per acc.
  - stat_redirect +1 per acc with jr|jmp|br_taken, and per flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0x3000, zero-wait mem, id_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; first if_valid 2 cycles after reset release.
- if_pc=0x3010 with jmp=1, jump_addr=0x0040_0020 -> pc_hi=0x0; next imem_addr=0x0040_0020; no sequential 0x3014 instruction reaches decode.
- if_pc=0x3000, br_taken=1, br_offset=16'hFFFF -> next fetch 0x3000; jr=1 and jmp=1 together with jr_addr=0x5000 -> 0x5000.
- id_ready=0 for 5 cycles -> if_instr/if_pc stable, imem_req=0; release -> sequential fetch resumes with no loss or duplicate.
- imem_ack delayed 3 cycles, flush with flush_pc=0x80 in wait cycle 1 -> addr held, late data dropped, next request 0x80, if_valid stays 0 meanwhile.
- if_pc=0xFFFF_FFFC sequential -> next fetch 0x0000_0000; rst_n low during DROP -> immediate outputs 0, restart at RESET_PC.
